// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one outstanding load/store from the core data port, one RSP_VALID pulse per request.
// A per-transaction cycle timeout converts a silent slave into an error response.
module axi_lite_master #(
    parameter int unsigned AXI_AWIDTH     = 32,
    parameter int unsigned AXI_DWIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,

    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic                    REQ_WE,
    input  logic [AXI_AWIDTH-1:0]   REQ_ADDR,
    input  logic [AXI_DWIDTH-1:0]   REQ_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] REQ_WSTRB,

    output logic                    RSP_VALID,
    output logic [AXI_DWIDTH-1:0]   RSP_RDATA,
    output logic                    RSP_ERR,
    output logic                    RSP_TIMEOUT,

    output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
    output logic [2:0]              AXI_AWPROT,
    output logic                    AXI_AWVALID,
    input  logic                    AXI_AWREADY,

    output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
    output logic                    AXI_WVALID,
    input  logic                    AXI_WREADY,

    input  logic [1:0]              AXI_BRESP,
    input  logic                    AXI_BVALID,
    output logic                    AXI_BREADY,

    output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
    output logic [2:0]              AXI_ARPROT,
    output logic                    AXI_ARVALID,
    input  logic                    AXI_ARREADY,

    input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]              AXI_RRESP,
    input  logic                    AXI_RVALID,
    output logic                    AXI_RREADY
);

    localparam int unsigned STRB_W    = AXI_DWIDTH / 8;
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_to_q, rsp_to_d;
    logic [AXI_DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic accept, active, to_hit, abort;
    logic aw_pend, w_pend, b_fire, ar_fire, r_fire;
    logic unused_resp_lsb;

    assign unused_resp_lsb = AXI_BRESP[0] ^ AXI_RRESP[0];

    assign accept  = REQ_VALID && req_ready_q;
    assign active  = (state_q == S_WR_ADDR_DATA) || (state_q == S_WR_RESP) ||
                     (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    assign to_hit  = (TIMEOUT_CYCLES != 0) && active && (cnt_q == TO_LAST);
    assign aw_pend = awvalid_q && !AXI_AWREADY;
    assign w_pend  = wvalid_q && !AXI_WREADY;
    assign b_fire  = bready_q && AXI_BVALID;
    assign ar_fire = arvalid_q && AXI_ARREADY;
    assign r_fire  = rready_q && AXI_RVALID;

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // A handshake that completes on the timeout edge takes priority over the abort.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        unique case (state_q)
            S_IDLE:         if (accept) state_d = REQ_WE ? S_WR_ADDR_DATA : S_RD_ADDR;
            S_WR_ADDR_DATA: if (!aw_pend && !w_pend) state_d = S_WR_RESP;
                            else if (to_hit) abort = 1'b1;
            S_WR_RESP:      if (b_fire) state_d = S_RESP;
                            else if (to_hit) abort = 1'b1;
            S_RD_ADDR:      if (ar_fire) state_d = S_RD_DATA;
                            else if (to_hit) abort = 1'b1;
            S_RD_DATA:      if (r_fire) state_d = S_RESP;
                            else if (to_hit) abort = 1'b1;
            S_RESP:         state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
        if (abort) state_d = S_RESP;
    end

    always_comb begin
        awvalid_d   = (state_d == S_WR_ADDR_DATA) && ((state_q == S_IDLE) || aw_pend);
        wvalid_d    = (state_d == S_WR_ADDR_DATA) && ((state_q == S_IDLE) || w_pend);
        bready_d    = (state_d == S_WR_RESP);
        arvalid_d   = (state_d == S_RD_ADDR);
        rready_d    = (state_d == S_RD_DATA);
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);

        // Counter saturates so a late phase still meets the same limit.
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (active && (cnt_q != TO_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (accept) begin
            addr_d = REQ_ADDR;
            if (REQ_WE) begin
                wdata_d = REQ_WDATA;
                wstrb_d = REQ_WSTRB;
            end
        end

        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        rsp_rdata_d = rsp_rdata_q;
        if (abort) begin
            rsp_err_d = 1'b1;
            rsp_to_d  = 1'b1;
        end else if ((state_q == S_WR_RESP) && b_fire) begin
            rsp_err_d = AXI_BRESP[1];
            rsp_to_d  = 1'b0;
        end else if ((state_q == S_RD_DATA) && r_fire) begin
            rsp_err_d   = AXI_RRESP[1];
            rsp_to_d    = 1'b0;
            rsp_rdata_d = AXI_RDATA;
        end
    end

    assign REQ_READY   = req_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_TIMEOUT = rsp_to_q;

    assign AXI_AWADDR  = addr_q;
    assign AXI_AWPROT  = 3'b000;
    assign AXI_AWVALID = awvalid_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = wstrb_q;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_BREADY  = bready_q;
    assign AXI_ARADDR  = addr_q;
    assign AXI_ARPROT  = 3'b000;
    assign AXI_ARVALID = arvalid_q;
    assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: scripted slave with per-channel delays, transaction-level timing model.
module tb_axi_lite_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        REQ_VALID = 1'b0, REQ_READY, REQ_WE = 1'b0;
    logic [31:0] REQ_ADDR = '0, REQ_WDATA = '0;
    logic [3:0]  REQ_WSTRB = '0;
    logic        RSP_VALID, RSP_ERR, RSP_TIMEOUT;
    logic [31:0] RSP_RDATA;
    logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR;
    logic [2:0]  AXI_AWPROT, AXI_ARPROT;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY;
    logic        AXI_AWREADY = 1'b0, AXI_WREADY = 1'b0, AXI_BVALID = 1'b0;
    logic        AXI_ARREADY = 1'b0, AXI_RVALID = 1'b0;
    logic [1:0]  AXI_BRESP = '0, AXI_RRESP = '0;
    logic [31:0] AXI_RDATA = '0;

    always #5 clk = ~clk;

    axi_lite_master #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rdata = '0;

    // Observations of the last transaction, cycle numbers counted from the accept edge.
    int          o_rsp_cnt, o_rsp_cyc, o_rdy_cyc, o_aw_cyc, o_w_cyc, o_ar_cyc, o_viol;
    logic        o_err, o_to;
    logic [31:0] o_rdata, o_awaddr, o_wdata;
    logic [3:0]  o_wstrb;

    // Cycle in which RSP_VALID is expected; edges where each phase completes decide against the limit.
    function automatic int model_rsp_cyc(input logic we, input int aw_d, w_d, b_d, ar_d, r_d,
                                         output logic to);
        int e1, e2, tk;
        if (we) begin
            e1 = 1 + ((aw_d > w_d) ? aw_d : w_d);
            e2 = e1 + 1 + b_d;
        end else begin
            e1 = 1 + ar_d;
            e2 = e1 + 1 + r_d;
        end
        tk = TO;
        to = 1'b0;
        if (e1 > tk) begin to = 1'b1; return tk + 1; end
        if (e1 == tk) tk++;
        if (e2 > tk) begin to = 1'b1; return tk + 1; end
        return e2 + 1;
    endfunction

    task automatic clear_slave();
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_ARREADY = 0; AXI_RVALID = 0;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, wdata, input logic [3:0] wstrb,
                           input int aw_d, w_d, b_d, ar_d, r_d,
                           input logic [1:0] resp, input logic [31:0] rdata);
        int  waitc, aw_e, w_e, ar_e;
        bit  aw_done, w_done, b_done, ar_done, r_done;
        o_rsp_cnt = 0; o_rsp_cyc = -1; o_rdy_cyc = -1; o_aw_cyc = 0; o_w_cyc = 0; o_ar_cyc = 0;
        o_viol = 0; o_err = 0; o_to = 0; o_rdata = '0; o_awaddr = '0; o_wdata = '0; o_wstrb = '0;
        aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0; aw_e = 0; w_e = 0; ar_e = 0;
        waitc = 0;
        @(negedge clk);
        while (!REQ_READY && waitc < 20) begin @(negedge clk); waitc++; end
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: REQ_READY=%b, required 1", REQ_READY);
        end
        REQ_VALID = 1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_WSTRB = wstrb;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) REQ_VALID = 0;
            if (REQ_READY && o_rsp_cyc < 0) o_viol++;
            if (REQ_READY && o_rdy_cyc < 0) o_rdy_cyc = c;
            if (RSP_VALID) begin
                o_rsp_cnt++;
                if (o_rsp_cyc < 0) o_rsp_cyc = c;
                o_err = RSP_ERR; o_to = RSP_TIMEOUT; o_rdata = RSP_RDATA;
            end
            if (AXI_AWVALID) begin o_aw_cyc++; if (AXI_AWADDR !== addr) o_viol++; end
            if (AXI_WVALID) begin
                o_w_cyc++;
                if (AXI_WDATA !== wdata || AXI_WSTRB !== wstrb) o_viol++;
            end
            if (AXI_ARVALID) begin o_ar_cyc++; if (AXI_ARADDR !== addr) o_viol++; end
            if (AXI_ARVALID && AXI_RREADY) o_viol++;
            if (AXI_AWPROT !== 3'b000 || AXI_ARPROT !== 3'b000) o_viol++;
            if (o_rsp_cyc >= 0 && (AXI_AWVALID | AXI_WVALID | AXI_BREADY | AXI_ARVALID | AXI_RREADY)) o_viol++;
            if (we) begin
                AXI_AWREADY = !aw_done && (c >= 1 + aw_d);
                if (AXI_AWVALID && AXI_AWREADY) begin aw_done = 1; aw_e = c; o_awaddr = AXI_AWADDR; end
                AXI_WREADY = !w_done && (c >= 1 + w_d);
                if (AXI_WVALID && AXI_WREADY) begin
                    w_done = 1; w_e = c; o_wdata = AXI_WDATA; o_wstrb = AXI_WSTRB;
                end
                AXI_BRESP  = resp;
                AXI_BVALID = aw_done && w_done && !b_done && (c >= ((aw_e > w_e) ? aw_e : w_e) + 1 + b_d);
                if (AXI_BVALID && AXI_BREADY) b_done = 1;
            end else begin
                AXI_ARREADY = !ar_done && (c >= 1 + ar_d);
                if (AXI_ARVALID && AXI_ARREADY) begin ar_done = 1; ar_e = c; end
                AXI_RDATA  = rdata;
                AXI_RRESP  = resp;
                AXI_RVALID = ar_done && !r_done && (c >= ar_e + 1 + r_d);
                if (AXI_RVALID && AXI_RREADY) r_done = 1;
            end
        end
        clear_slave();
    endtask

    task automatic test_reset();
        rst = 0;
        #3 rst = 1;
        #1;
        checks++;
        if ({AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY} !== 5'b0) begin
            errors++; $display("FAIL reset_vld_rdy: got %b, required 00000",
                {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY});
        end
        checks++;
        if ({AXI_AWADDR, AXI_WDATA, AXI_WSTRB, AXI_ARADDR} !== '0) begin
            errors++; $display("FAIL reset_axi_payload: awaddr=%h wdata=%h wstrb=%h araddr=%h, required 0",
                AXI_AWADDR, AXI_WDATA, AXI_WSTRB, AXI_ARADDR);
        end
        checks++;
        if ({REQ_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT} !== 4'b0 || RSP_RDATA !== 32'h0) begin
            errors++; $display("FAIL reset_core_side: rdy/vld/err/to=%b rdata=%h, required 0",
                {REQ_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT}, RSP_RDATA);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        #1;
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: REQ_READY=%b, required 0", REQ_READY);
        end
        @(posedge clk) #1;
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge: REQ_READY=%b, required 1", REQ_READY);
        end
    endtask

    task automatic test_write_basic();
        run_txn(1, 32'hF000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0);
        checks++;
        if (o_awaddr !== 32'hF000_0000 || o_wdata !== 32'hDEAD_BEEF || o_wstrb !== 4'hF) begin
            errors++; $display("FAIL wr_payload: awaddr=%h wdata=%h wstrb=%h, required f0000000 deadbeef f",
                o_awaddr, o_wdata, o_wstrb);
        end
        checks++;
        if (o_aw_cyc !== 1 || o_w_cyc !== 1) begin
            errors++; $display("FAIL wr_valid_len: aw=%0d w=%0d cycles, required 1 1", o_aw_cyc, o_w_cyc);
        end
        checks++;
        if (o_rsp_cyc !== 3 || o_rdy_cyc !== 4 || o_rsp_cnt !== 1) begin
            errors++; $display("FAIL wr_timing: rsp_cyc=%0d rdy_cyc=%0d cnt=%0d, required 3 4 1",
                o_rsp_cyc, o_rdy_cyc, o_rsp_cnt);
        end
        checks++;
        if (o_err !== 1'b0 || o_to !== 1'b0 || o_viol !== 0) begin
            errors++; $display("FAIL wr_status: err=%b to=%b viol=%0d, required 0 0 0", o_err, o_to, o_viol);
        end
    endtask

    task automatic test_write_w_first();
        run_txn(1, 32'h0000_0040, 32'h0102_0304, 4'h5, 3, 0, 0, 0, 0, 2'b00, 32'h0);
        checks++;
        if (o_w_cyc !== 1 || o_aw_cyc !== 4) begin
            errors++; $display("FAIL wfirst_valid_len: w=%0d aw=%0d cycles, required 1 4", o_w_cyc, o_aw_cyc);
        end
        checks++;
        if (o_rsp_cnt !== 1 || o_rsp_cyc !== 6 || o_err !== 1'b0 || o_viol !== 0) begin
            errors++; $display("FAIL wfirst_rsp: cnt=%0d cyc=%0d err=%b viol=%0d, required 1 6 0 0",
                o_rsp_cnt, o_rsp_cyc, o_err, o_viol);
        end
    endtask

    task automatic test_read_wait();
        run_txn(0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h1234_5678);
        exp_rdata = 32'h1234_5678;
        checks++;
        if (o_rdata !== exp_rdata || o_err !== 1'b0 || o_to !== 1'b0) begin
            errors++; $display("FAIL rd_data: rdata=%h err=%b to=%b, required %h 0 0", o_rdata, o_err, o_to, exp_rdata);
        end
        checks++;
        if (o_rsp_cyc !== 5 || o_ar_cyc !== 1 || o_viol !== 0) begin
            errors++; $display("FAIL rd_timing: rsp_cyc=%0d ar=%0d viol=%0d, required 5 1 0", o_rsp_cyc, o_ar_cyc, o_viol);
        end
    endtask

    task automatic test_timeout();
        run_txn(0, 32'hF000_0004, 32'h0, 4'h0, 0, 0, 0, 20, 0, 2'b00, 32'h0);
        checks++;
        if (o_ar_cyc !== TO || o_rsp_cyc !== TO + 1 || o_rsp_cnt !== 1) begin
            errors++; $display("FAIL to_timing: ar=%0d rsp_cyc=%0d cnt=%0d, required %0d %0d 1",
                o_ar_cyc, o_rsp_cyc, o_rsp_cnt, TO, TO + 1);
        end
        checks++;
        if (o_err !== 1'b1 || o_to !== 1'b1 || o_rdata !== exp_rdata || o_viol !== 0) begin
            errors++; $display("FAIL to_status: err=%b to=%b rdata=%h viol=%0d, required 1 1 %h 0",
                o_err, o_to, o_rdata, o_viol, exp_rdata);
        end
        run_txn(0, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_F00D);
        exp_rdata = 32'hCAFE_F00D;
        checks++;
        if (o_rsp_cyc !== 3 || o_rdata !== exp_rdata || o_err !== 1'b0 || o_to !== 1'b0) begin
            errors++; $display("FAIL after_to_read: cyc=%0d rdata=%h err=%b to=%b, required 3 %h 0 0",
                o_rsp_cyc, o_rdata, o_err, o_to, exp_rdata);
        end
    endtask

    task automatic test_error_resp();
        run_txn(1, 32'h0000_0300, 32'h5555_AAAA, 4'h3, 0, 0, 1, 0, 0, 2'b10, 32'h0);
        checks++;
        if (o_err !== 1'b1 || o_to !== 1'b0 || o_rsp_cyc !== 4) begin
            errors++; $display("FAIL wr_slverr: err=%b to=%b cyc=%0d, required 1 0 4", o_err, o_to, o_rsp_cyc);
        end
        run_txn(0, 32'h0000_0304, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b11, 32'hA5A5_0F0F);
        exp_rdata = 32'hA5A5_0F0F;
        checks++;
        if (o_err !== 1'b1 || o_to !== 1'b0 || o_rdata !== exp_rdata) begin
            errors++; $display("FAIL rd_decerr: err=%b to=%b rdata=%h, required 1 0 %h", o_err, o_to, o_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        REQ_VALID = 1; REQ_WE = 1; REQ_ADDR = 32'h10; REQ_WDATA = 32'h77; REQ_WSTRB = 4'hF;
        AXI_AWREADY = 1; AXI_WREADY = 1;
        @(posedge clk);
        @(negedge clk) REQ_VALID = 0;
        @(negedge clk);
        AXI_AWREADY = 0; AXI_WREADY = 0;
        checks++;
        if (AXI_BREADY !== 1'b1) begin
            errors++; $display("FAIL mid_in_wr_resp: BREADY=%b, required 1", AXI_BREADY);
        end
        #1 rst = 1;
        #1;
        checks++;
        if (AXI_BREADY !== 1'b0 || REQ_READY !== 1'b0 || RSP_VALID !== 1'b0) begin
            errors++; $display("FAIL mid_reset_immediate: bready=%b req_ready=%b rsp_valid=%b, required 0 0 0",
                AXI_BREADY, REQ_READY, RSP_VALID);
        end
        pulses = 0;
        AXI_BVALID = 1;
        repeat (2) @(negedge clk) if (RSP_VALID) pulses++;
        rst = 0;
        AXI_BVALID = 0;
        repeat (4) @(negedge clk) if (RSP_VALID) pulses++;
        exp_rdata = '0;
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL mid_no_rsp: pulses=%0d, required 0", pulses);
        end
        run_txn(1, 32'h0000_0020, 32'h1357_9BDF, 4'hC, 0, 0, 0, 0, 0, 2'b00, 32'h0);
        checks++;
        if (o_rsp_cyc !== 3 || o_err !== 1'b0 || o_rdata !== exp_rdata || o_viol !== 0) begin
            errors++; $display("FAIL mid_recover: cyc=%0d err=%b rdata=%h viol=%0d, required 3 0 %h 0",
                o_rsp_cyc, o_err, o_rdata, o_viol, exp_rdata);
        end
    endtask

    function automatic int rnd_dly();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return $urandom_range(6, 8);
        return 20;
    endfunction

    task automatic test_random();
        logic        we, to_e;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        int          awd, wd, bd, ard, rd, cyc_e;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            wstrb = 4'($urandom_range(0, 15)); resp = 2'($urandom_range(0, 3));
            awd = rnd_dly(); wd = rnd_dly(); bd = rnd_dly(); ard = rnd_dly(); rd = rnd_dly();
            cyc_e = model_rsp_cyc(we, awd, wd, bd, ard, rd, to_e);
            if (!we && !to_e) exp_rdata = rdata;
            run_txn(we, addr, wdata, wstrb, awd, wd, bd, ard, rd, resp, rdata);
            checks++;
            if (o_rsp_cnt !== 1 || o_rsp_cyc !== cyc_e || o_rdy_cyc !== cyc_e + 1) begin
                errors++; $display("FAIL rand%0d_timing: cnt=%0d cyc=%0d rdy=%0d, required 1 %0d %0d",
                    i, o_rsp_cnt, o_rsp_cyc, o_rdy_cyc, cyc_e, cyc_e + 1);
            end
            checks++;
            if (o_err !== (to_e | resp[1]) || o_to !== to_e || o_rdata !== exp_rdata) begin
                errors++; $display("FAIL rand%0d_rsp: err=%b to=%b rdata=%h, required %b %b %h",
                    i, o_err, o_to, o_rdata, to_e | resp[1], to_e, exp_rdata);
            end
            checks++;
            if (o_viol !== 0) begin
                errors++; $display("FAIL rand%0d_protocol: violations=%0d, required 0", i, o_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_w_first();
        test_read_wait();
        test_timeout();
        test_error_resp();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
